// File: rtl/fetch_decode_reg.sv
// fetch_decode_reg: F/D pipeline register with fetch-fault detection,
// flush bubble insertion, stall hold and a stall-cycle counter.
// Optional feature: define FETCH_RANGE_CHECK_EN to also fault on PC_F
// outside the instruction-memory window 0x00003000..0x00006FFC.
module fetch_decode_reg (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        En,
    input  logic        Flush,
    input  logic [31:0] PC_F,
    input  logic [31:0] Instr_F,
    input  logic        BD_F,
    output logic [31:0] PC_D,
    output logic [31:0] Instr_D,
    output logic [31:0] PC8_D,
    output logic        BD_D,
    output logic [4:0]  ExcCode_D,
    output logic        Valid_D,
    output logic [31:0] StallCnt
);

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IM_LO      = 32'h0000_3000;
    localparam logic [31:0] IM_HI      = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;

    // Declaration initialisers give defined values at time 0.
    logic [31:0] pc_q       = RESET_PC;
    logic [31:0] instr_q    = '0;
    logic [31:0] pc8_q      = RESET_PC + 32'd8;
    logic        bd_q       = 1'b0;
    logic [4:0]  exc_code_q = EXC_NONE;
    logic        valid_q    = 1'b0;
    logic [31:0] stall_cnt_q = '0;

    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic [31:0] pc8_d;
    logic        bd_d;
    logic [4:0]  exc_code_d;
    logic        valid_d;
    logic [31:0] stall_cnt_d;
    logic        fetch_fault;

    // Fetch fault: misaligned PC, plus out-of-window PC when range check is built in.
    always_comb begin
        fetch_fault = (PC_F[1:0] != 2'b00);
`ifdef FETCH_RANGE_CHECK_EN
        if ((PC_F < IM_LO) || (PC_F > IM_HI)) begin
            fetch_fault = 1'b1;
        end
`endif
    end

    // Next-state selection with priority reset > flush > stall > load.
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc8_d       = pc8_q;
        bd_d        = bd_q;
        exc_code_d  = exc_code_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        if (Reset) begin
            pc_d        = RESET_PC;
            instr_d     = '0;
            pc8_d       = RESET_PC + 32'd8;
            bd_d        = 1'b0;
            exc_code_d  = EXC_NONE;
            valid_d     = 1'b0;
            stall_cnt_d = '0;
        end else if (Flush) begin
            pc_d       = HANDLER_PC;
            instr_d    = '0;
            pc8_d      = HANDLER_PC + 32'd8;
            bd_d       = 1'b0;
            exc_code_d = EXC_NONE;
            valid_d    = 1'b0;
        end else if (!En) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            pc_d       = PC_F;
            pc8_d      = PC_F + 32'd8;
            bd_d       = BD_F;
            valid_d    = 1'b1;
            instr_d    = fetch_fault ? 32'd0 : Instr_F;
            exc_code_d = fetch_fault ? EXC_ADEL : EXC_NONE;
        end
    end

    // Pipeline register update.
    always_ff @(posedge Clk) begin
        pc_q        <= pc_d;
        instr_q     <= instr_d;
        pc8_q       <= pc8_d;
        bd_q        <= bd_d;
        exc_code_q  <= exc_code_d;
        valid_q     <= valid_d;
        stall_cnt_q <= stall_cnt_d;
    end

    assign PC_D      = pc_q;
    assign Instr_D   = instr_q;
    assign PC8_D     = pc8_q;
    assign BD_D      = bd_q;
    assign ExcCode_D = exc_code_q;
    assign Valid_D   = valid_q;
    assign StallCnt  = stall_cnt_q;

endmodule
